madd_err_accum: RTL
===================

MADD_ERR_ACCUM -- requirements
Module: madd_err_accum

Interface
REQ-001 Parameter W, default 12: width of the multiply-add result words being compared.
REQ-002 Parameter CNT_W, default 19: sample-counter width, which covers an exhaustive 2^18-vector sweep.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse: clear all results and begin a run.
REQ-006 n_samples  input  CNT_W  number of samples in the run; sampled only on the cycle start is accepted.
REQ-007 in_valid  input  1  approx/exact pair is present.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 approx  input  W  approximate circuit output (g401..g412 packed, g412 = MSB).
REQ-010 exact  input  W  golden exact result for the same input vector.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  run complete; all result outputs are final.
REQ-013 sample_cnt  output  CNT_W  pairs accepted in the current run.
REQ-014 err_cnt  output  CNT_W  pairs with approx != exact.
REQ-015 sum_ed  output  W+CNT_W  sum of |approx - exact|, unsigned.
REQ-016 max_ed  output  W  largest |approx - exact| in the run.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN and DONE, and busy SHALL equal (state == RUN).
REQ-018 In IDLE, start SHALL clear all results, latch n_samples, and go to RUN, or go to DONE if n_samples == 0.
REQ-019 in_ready SHALL be 1 only in RUN; an accept is in_valid & in_ready.
REQ-020 On each accept, the block SHALL compute ed = |approx - exact| as a W-bit unsigned value.
REQ-021 On each accept, the block SHALL update sample_cnt += 1, err_cnt += (ed != 0), sum_ed += ed, and max_ed = max(max_ed, ed).
REQ-022 All updates SHALL be registered, so results are visible the cycle after the accept.
REQ-023 The accept that makes sample_cnt == latched n_samples SHALL move the FSM to DONE, with done = 1 and final values visible on the next cycle.
REQ-024 In DONE, done SHALL stay high and the results SHALL stay stable until the next start.
REQ-025 A start in DONE SHALL behave as a start in IDLE.
REQ-026 A start in RUN SHALL restart the run: results clear, n_samples is relatched, and any same-cycle input pair is discarded.
REQ-027 in_valid outside RUN SHALL be ignored and SHALL not be stalled; the block has no backpressure beyond in_ready.
REQ-028 Accumulator widths SHALL be sized so that no overflow occurs for n_samples <= 2^CNT_W - 1, and no saturation logic is required.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously enter IDLE with busy = 0, done = 0, in_ready = 0, and all counters and accumulators (including sum_sq, if present) at 0.
REQ-030 Reset asserted mid-run SHALL abandon the run, with no partial results retained.
REQ-031 After rst_n rises, the first rising clk edge SHALL act on start.

Configuration
REQ-032 With MADD_ERR_SQ_EN defined, the block SHALL add output sum_sq (2*W+CNT_W bits), which accumulates ed*ed on every accept with the same clear and timing as sum_ed.
REQ-033 Without MADD_ERR_SQ_EN, the sum_sq port and its multiplier SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-034 Scenario: reset, start with n_samples=3, pairs (5,5), (10,7), (0,4095). Required: err_cnt=2, sum_ed=4098, max_ed=4095, sample_cnt=3, done=1 one cycle after the 3rd accept.
REQ-035 Scenario: start with n_samples=0. Required: done=1 on the next cycle, in_ready never asserted, all results 0.
REQ-036 Scenario: n_samples=4, in_valid toggling 1,0,1,0,... with pairs (1,2). Required: only the 4 accepted pairs count; sum_ed=4; done follows the 4th accept.
REQ-037 Scenario: start in RUN after 2 accepts, with in_valid high on that cycle. Required: results 0, that pair discarded, the new n_samples honoured.
REQ-038 Scenario: rst_n low for 1 cycle mid-run. Required: state IDLE, all outputs 0, subsequent start runs normally.
REQ-039 Scenario: with MADD_ERR_SQ_EN defined, pairs (0,3) and (8,4) with n_samples=2. Required: sum_sq=25, sum_ed=7.

Source files
------------

// File: rtl/madd_err_accum.sv
// madd_err_accum: compares approximate vs exact multiply-add results and accumulates error stats.
// Latency: results are registered and visible the cycle after each accept; done follows the last accept by one cycle.
// Backpressure: in_ready is high only while running; in_valid outside a run is dropped, never stalled.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   start, n_samples      one-cycle run start (from any state) and run length, latched on start
//   in_valid/in_ready     approx/exact pair handshake; approx packs g401..g412 with g412 as MSB
//   busy, done            run in progress / run finished with final results
//   sample_cnt, err_cnt   accepted pairs / pairs with approx != exact
//   sum_ed, max_ed        sum and maximum of |approx - exact|
//   sum_sq                sum of |approx - exact|^2, present only when MADD_ERR_SQ_EN is defined
module madd_err_accum #(
  parameter int W     = 12,
  parameter int CNT_W = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       approx,
  input  logic [W-1:0]       exact,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [W+CNT_W-1:0] sum_ed,
  output logic [W-1:0]       max_ed
`ifdef MADD_ERR_SQ_EN
  ,
  output logic [2*W+CNT_W-1:0] sum_sq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               last;
  logic [W-1:0]       ed;

  // A start in RUN wins over a same-cycle pair: the pair is dropped, not counted.
  assign accept  = (state_q == S_RUN) && in_valid && !start;
  assign ed      = (approx >= exact) ? (approx - exact) : (exact - approx);
  assign cnt_nxt = sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last    = (cnt_nxt == n_lat);

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign in_ready = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (n_samples == '0) ? S_DONE : S_RUN;
    end else if (accept && last) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat      <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else if (start) begin
      n_lat      <= n_samples;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else if (accept) begin
      sample_cnt <= cnt_nxt;
      err_cnt    <= err_cnt + {{(CNT_W-1){1'b0}}, (ed != '0)};
      sum_ed     <= sum_ed + {{CNT_W{1'b0}}, ed};
      if (ed > max_ed) begin
        max_ed <= ed;
      end
    end
  end

`ifdef MADD_ERR_SQ_EN
  logic [2*W-1:0] ed_sq;

  assign ed_sq = {{W{1'b0}}, ed} * {{W{1'b0}}, ed};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq <= '0;
    end else if (start) begin
      sum_sq <= '0;
    end else if (accept) begin
      sum_sq <= sum_sq + {{CNT_W{1'b0}}, ed_sq};
    end
  end
`endif

endmodule
